// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment scan driver: glyph table,
// special cathode patterns and the load/convert/commit FSM encoding.
package ssd_pkg;

   localparam logic [7:0] CATH_BLANK = 8'hFF;
   localparam logic [7:0] CATH_DASH  = 8'b1111_1101;

   // Active-low abcdefg patterns; entry 0 is the last element.
   localparam logic [15:0][6:0] GLYPH_TABLE = {
      7'b0111000,
      7'b0110000,
      7'b1000010,
      7'b0110001,
      7'b1100000,
      7'b0001000,
      7'b0000100,
      7'b0000000,
      7'b0001111,
      7'b0100000,
      7'b0100100,
      7'b1001100,
      7'b0000110,
      7'b0010010,
      7'b1001111,
      7'b0000001
   };

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CONVERT = 2'd1,
      ST_COMMIT  = 2'd2
   } ssd_state_e;

   function automatic logic [6:0] ssd_glyph(input logic [3:0] nibble);
      return GLYPH_TABLE[nibble];
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: one shift per cycle, VALUE_WIDTH cycles,
// with a guard nibble and sticky carry to flag results wider than NUM_DIGITS.
module bin2bcd_seq #(
   parameter int unsigned VALUE_WIDTH = 16,
   parameter int unsigned NUM_DIGITS  = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [VALUE_WIDTH-1:0]    bin,
   output logic [NUM_DIGITS*4-1:0]   bcd,
   output logic                      overflow,
   output logic                      done_c
);

   localparam int unsigned BCD_W = NUM_DIGITS * 4 + 4;
   localparam int unsigned CNT_W = $clog2(VALUE_WIDTH + 1);

   logic [VALUE_WIDTH-1:0] shreg;
   logic [BCD_W-1:0]       acc;
   logic [BCD_W-1:0]       adj;
   logic [CNT_W-1:0]       cnt;
   logic                   running;
   logic                   ovf;

   // Add-3 correction on every nibble (guard included) before the shift.
   always_comb begin
      adj = acc;
      for (int i = 0; i < int'(NUM_DIGITS) + 1; i++) begin
         if (acc[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
      end
   end

   assign done_c = running && (cnt == CNT_W'(VALUE_WIDTH - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         shreg   <= '0;
         acc     <= '0;
         cnt     <= '0;
         running <= 1'b0;
         ovf     <= 1'b0;
      end else if (start) begin
         shreg   <= bin;
         acc     <= '0;
         cnt     <= '0;
         running <= 1'b1;
         ovf     <= 1'b0;
      end else if (running) begin
         acc   <= {adj[BCD_W-2:0], shreg[VALUE_WIDTH-1]};
         shreg <= shreg << 1;
         // Once the guard nibble is nonzero it stays nonzero or carries out.
         ovf   <= ovf | adj[BCD_W-1] | (|adj[BCD_W-2:BCD_W-5]);
         cnt   <= cnt + CNT_W'(1);
         if (done_c) running <= 1'b0;
      end
   end

   assign bcd      = acc[NUM_DIGITS*4-1:0];
   assign overflow = ovf;

endmodule

// File: rtl/ssd_scan_driver.sv
// Multiplexed common-anode seven-segment driver: hex or BCD conversion,
// atomic commit to a display register, and continuous digit scanning.
module ssd_scan_driver
   import ssd_pkg::*;
#(
   parameter int unsigned NUM_DIGITS  = 8,
   parameter int unsigned VALUE_WIDTH = 16,
   parameter int unsigned SCAN_CYCLES = 100000
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic [VALUE_WIDTH-1:0] Value,
   input  logic                   Load,
   input  logic                   Mode,
   input  logic                   BlankLeading,
   input  logic [NUM_DIGITS-1:0]  DpMask,
   output logic                   Busy,
   output logic                   Overflow,
   output logic [NUM_DIGITS-1:0]  An,
   output logic [7:0]             Cathodes
);

   localparam int unsigned DIG_W = NUM_DIGITS * 4;
   localparam int unsigned EXT_W = (VALUE_WIDTH > DIG_W) ? VALUE_WIDTH : DIG_W;
   localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned PRE_W = $clog2(SCAN_CYCLES);

   ssd_state_e             state;
   ssd_state_e             next_state;
   logic                   accept_c;
   logic                   start_c;
   logic                   commit_c;
   logic [VALUE_WIDTH-1:0] value_q;
   logic                   mode_q;
   logic                   blank_q;
   logic [DIG_W-1:0]       bcd;
   logic                   bcd_ovf;
   logic                   conv_done_c;
   logic [EXT_W-1:0]       hex_ext;
   logic [DIG_W-1:0]       nib_c;
   logic                   ovf_c;
   logic [NUM_DIGITS-1:0]  blank_c;
   logic                   zero_run;
   logic [DIG_W-1:0]       disp_digits;
   logic [NUM_DIGITS-1:0]  disp_blank;
   logic [PRE_W-1:0]       presc;
   logic [IDX_W-1:0]       idx;
   logic [3:0]             cur_nib;
   logic                   digit_on_c;

   bin2bcd_seq #(
      .VALUE_WIDTH (VALUE_WIDTH),
      .NUM_DIGITS  (NUM_DIGITS)
   ) u_bin2bcd (
      .clk      (Clk),
      .reset    (Reset),
      .start    (start_c),
      .bin      (Value),
      .bcd      (bcd),
      .overflow (bcd_ovf),
      .done_c   (conv_done_c)
   );

   always_ff @(posedge Clk) begin
      if (Reset) state <= ST_IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      accept_c   = 1'b0;
      start_c    = 1'b0;
      commit_c   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (Load && !Busy) begin
               accept_c   = 1'b1;
               start_c    = Mode;
               next_state = Mode ? ST_CONVERT : ST_COMMIT;
            end
         end
         ST_CONVERT: if (conv_done_c) next_state = ST_COMMIT;
         ST_COMMIT: begin
            commit_c   = 1'b1;
            next_state = ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // Digit nibbles, overflow and leading-zero mask for the commit cycle.
   always_comb begin
      hex_ext  = EXT_W'(value_q);
      nib_c    = mode_q ? bcd : hex_ext[DIG_W-1:0];
      ovf_c    = mode_q ? bcd_ovf : |(hex_ext >> DIG_W);
      blank_c  = '0;
      zero_run = 1'b1;
      for (int i = int'(NUM_DIGITS) - 1; i > 0; i--) begin
         zero_run   = zero_run & (nib_c[i*4 +: 4] == 4'd0);
         blank_c[i] = blank_q & zero_run;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         Busy        <= 1'b0;
         value_q     <= '0;
         mode_q      <= 1'b0;
         blank_q     <= 1'b0;
         disp_digits <= '0;
         disp_blank  <= ~NUM_DIGITS'(1);
         Overflow    <= 1'b0;
      end else begin
         Busy <= (next_state != ST_IDLE);
         if (accept_c) begin
            value_q <= Value;
            mode_q  <= Mode;
            blank_q <= BlankLeading;
         end
         if (commit_c) begin
            disp_digits <= nib_c;
            disp_blank  <= blank_c;
            Overflow    <= ovf_c;
         end
      end
   end

   // Free-running scan prescaler and digit index.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         presc <= '0;
         idx   <= '0;
      end else if (presc == PRE_W'(SCAN_CYCLES - 1)) begin
         presc <= '0;
         idx   <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
      end else begin
         presc <= presc + PRE_W'(1);
      end
   end

   always_comb begin
      cur_nib    = disp_digits[{idx, 2'b00} +: 4];
      digit_on_c = Overflow | ~disp_blank[idx];
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         An       <= '1;
         Cathodes <= CATH_BLANK;
      end else begin
         An <= digit_on_c ? ~(NUM_DIGITS'(1) << idx) : '1;
         if (Overflow)        Cathodes <= {CATH_DASH[7:1], ~DpMask[idx]};
         else if (digit_on_c) Cathodes <= {ssd_glyph(cur_nib), ~DpMask[idx]};
         else                 Cathodes <= CATH_BLANK;
      end
   end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Directed bench for ssd_scan_driver: an 8-digit and a 4-digit instance
// with a short scan period, checked against hand-computed cathode patterns.
module tb_ssd_scan_driver;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [15:0] Value;
   logic        Mode, BlankLeading, load_a, load_b;
   logic [7:0]  DpMask;
   logic        busy_a, ovf_a, busy_b, ovf_b;
   logic [7:0]  an_a, cath_a, cath_b;
   logic [3:0]  an_b;

   always #5 Clk = ~Clk;

   ssd_scan_driver #(.NUM_DIGITS(8), .VALUE_WIDTH(16), .SCAN_CYCLES(4)) dut_a (
      .Clk(Clk), .Reset(Reset), .Value(Value), .Load(load_a), .Mode(Mode),
      .BlankLeading(BlankLeading), .DpMask(DpMask), .Busy(busy_a),
      .Overflow(ovf_a), .An(an_a), .Cathodes(cath_a));

   ssd_scan_driver #(.NUM_DIGITS(4), .VALUE_WIDTH(16), .SCAN_CYCLES(4)) dut_b (
      .Clk(Clk), .Reset(Reset), .Value(Value), .Load(load_b), .Mode(Mode),
      .BlankLeading(BlankLeading), .DpMask(DpMask[3:0]), .Busy(busy_b),
      .Overflow(ovf_b), .An(an_b), .Cathodes(cath_b));

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] snap_cath [8];
   logic [7:0] snap_seen;
   int         bad_step, wraps, multi_low;
   int         n;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Watch 12 digit slots and record the cathodes seen under each low anode.
   task automatic scan(input bit sel);
      logic [7:0] an;
      logic [7:0] ca;
      int nd, cur, prev, lows;
      nd = sel ? 4 : 8;
      prev = -1;
      snap_seen = '0;
      bad_step = 0; wraps = 0; multi_low = 0;
      for (int k = 0; k < 8; k++) snap_cath[k] = 8'hFF;
      repeat (48) begin
         @(negedge Clk);
         an = sel ? {4'hF, an_b} : an_a;
         ca = sel ? cath_b : cath_a;
         cur = -1; lows = 0;
         for (int i = 0; i < 8; i++) if (an[i] == 1'b0) begin cur = i; lows++; end
         if (lows > 1) multi_low++;
         if (cur >= 0) begin
            snap_seen[cur] = 1'b1;
            snap_cath[cur] = ca;
            if (prev >= 0 && cur != prev) begin
               if (cur != (prev + 1) % nd) bad_step++;
               if (prev == nd - 1 && cur == 0) wraps++;
            end
            prev = cur;
         end
      end
   endtask

   task automatic load_val(input bit sel, input logic [15:0] v, input logic m, input logic b);
      @(negedge Clk);
      Value = v; Mode = m; BlankLeading = b;
      if (sel) load_b = 1'b1; else load_a = 1'b1;
      @(negedge Clk);
      load_a = 1'b0; load_b = 1'b0;
   endtask

   task automatic count_busy(input bit sel, output int cnt);
      cnt = 0;
      while (((sel ? busy_b : busy_a) === 1'b1) && cnt < 200) begin
         cnt++;
         @(negedge Clk);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      Reset = 1'b1; Value = '0; Mode = 1'b0; BlankLeading = 1'b0;
      load_a = 1'b0; load_b = 1'b0; DpMask = '0;
      repeat (3) @(negedge Clk);
      chk("rst_an", an_a, 8'hFF);
      chk("rst_cath", cath_a, 8'hFF);
      chk("rst_busy", busy_a, 1'b0);
      chk("rst_ovf", ovf_a, 1'b0);
      chk("rst_an_b", an_b, 4'hF);
      Reset = 1'b0;
      scan(0);
      chk("rst_seen", snap_seen, 8'h01);
      chk("rst_dig0", snap_cath[0], 8'h03);

      // Decimal 1234 with leading-zero blanking.
      load_val(0, 16'd1234, 1'b1, 1'b1);
      count_busy(0, n);
      chk("dec_busy_cycles", n, 17);
      chk("dec_ovf", ovf_a, 1'b0);
      scan(0);
      chk("dec_seen", snap_seen, 8'h0F);
      chk("dec_digits", {snap_cath[3], snap_cath[2], snap_cath[1], snap_cath[0]}, 32'h9F250D99);

      // Hex BEEF without blanking: all digits lit, scan order checked.
      load_val(0, 16'hBEEF, 1'b0, 1'b0);
      count_busy(0, n);
      chk("hex_busy_cycles", n, 1);
      scan(0);
      chk("hex_seen", snap_seen, 8'hFF);
      chk("hex_lo", {snap_cath[3], snap_cath[2], snap_cath[1], snap_cath[0]}, 32'hC1616171);
      chk("hex_hi", {snap_cath[7], snap_cath[6], snap_cath[5], snap_cath[4]}, 32'h03030303);
      chk("scan_order", bad_step, 0);
      chk("scan_wrap", wraps > 0, 1'b1);
      chk("scan_onehot", multi_low, 0);

      // Four-digit instance: decimal overflow then a value that fits.
      load_val(1, 16'd12345, 1'b1, 1'b1);
      count_busy(1, n);
      chk("ovf_busy_cycles", n, 17);
      chk("ovf_flag", ovf_b, 1'b1);
      scan(1);
      chk("ovf_seen", snap_seen, 8'h0F);
      chk("ovf_dash", {snap_cath[3], snap_cath[2], snap_cath[1], snap_cath[0]}, 32'hFDFDFDFD);
      load_val(1, 16'd9999, 1'b1, 1'b1);
      count_busy(1, n);
      chk("fit_flag", ovf_b, 1'b0);
      scan(1);
      chk("fit_digits", {snap_cath[3], snap_cath[2], snap_cath[1], snap_cath[0]}, 32'h09090909);

      // A Load during conversion is ignored.
      load_val(0, 16'd42, 1'b1, 1'b1);
      repeat (4) @(negedge Clk);
      Value = 16'd7; load_a = 1'b1;
      @(negedge Clk);
      load_a = 1'b0;
      count_busy(0, n);
      scan(0);
      chk("busy_ign_seen", snap_seen, 8'h03);
      chk("busy_ign_digits", {snap_cath[1], snap_cath[0]}, 16'h9925);

      // A Load in the first cycle Busy is low is accepted.
      load_val(0, 16'd99, 1'b1, 1'b1);
      count_busy(0, n);
      Value = 16'h00A5; Mode = 1'b0; BlankLeading = 1'b1; load_a = 1'b1;
      @(negedge Clk);
      load_a = 1'b0;
      chk("drop_accept", busy_a, 1'b1);
      count_busy(0, n);
      scan(0);
      chk("drop_seen", snap_seen, 8'h03);
      chk("drop_digits", {snap_cath[1], snap_cath[0]}, 16'h1149);

      // Reset during conversion: nothing is committed.
      load_val(0, 16'd1234, 1'b1, 1'b1);
      repeat (4) @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      chk("abort_busy", busy_a, 1'b0);
      DpMask = 8'b0000_0100;
      scan(0);
      chk("abort_seen", snap_seen, 8'h01);
      chk("abort_dig0", snap_cath[0], 8'h03);
      chk("abort_ovf", ovf_a, 1'b0);

      // Live decimal point on digit 2.
      load_val(0, 16'h0000, 1'b0, 1'b0);
      count_busy(0, n);
      scan(0);
      chk("dp_seen", snap_seen, 8'hFF);
      chk("dp_digits", {snap_cath[3], snap_cath[2], snap_cath[1]}, 24'h030203);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
